// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: valid/ready bundle between register-file read, decode and the ALU
interface alu_decode_stage_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;
  modport master (
    output in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_alu_op, out_a, out_b, out_rd, out_we, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_alu_op, out_a, out_b, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV64I/Zba decode for the ALU; SKID_BUFFER_EN adds a one-entry skid with registered in_ready
module alu_decode_stage #(
  parameter int XLEN = 64,
  parameter bit ZBA  = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_decode_stage_if.slave bus
);
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_SH1ADD = 4'b0010;
  localparam logic [3:0] OP_SH2ADD = 4'b0011;
  localparam logic [3:0] OP_SH3ADD = 4'b0100;
  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } beat_t;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_add, is_sub, is_sh1, is_sh2, is_sh3, is_addi, legal;
  beat_t      dec, out_q;
  logic       out_valid;
  logic       unused_rs1_field;
  assign unused_rs1_field = ^bus.in_instr[19:15];
  always_comb begin
    op      = bus.in_instr[6:0];
    f3      = bus.in_instr[14:12];
    f7      = bus.in_instr[31:25];
    is_r    = op == 7'b0110011;
    is_add  = is_r && f3 == 3'b000 && f7 == 7'b0000000;
    is_sub  = is_r && f3 == 3'b000 && f7 == 7'b0100000;
    is_sh1  = ZBA && is_r && f7 == 7'b0010000 && f3 == 3'b010;
    is_sh2  = ZBA && is_r && f7 == 7'b0010000 && f3 == 3'b100;
    is_sh3  = ZBA && is_r && f7 == 7'b0010000 && f3 == 3'b110;
    is_addi = op == 7'b0010011 && f3 == 3'b000;
    legal   = is_add || is_sub || is_sh1 || is_sh2 || is_sh3 || is_addi;
    dec.op  = is_sub ? OP_SUB : is_sh1 ? OP_SH1ADD : is_sh2 ? OP_SH2ADD : is_sh3 ? OP_SH3ADD : OP_ADD;
    dec.a   = bus.in_rs1_data;
    dec.b   = is_addi ? {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]} : bus.in_rs2_data;
    dec.rd  = bus.in_instr[11:7];
    dec.we  = legal && bus.in_instr[11:7] != 5'd0;
    dec.ill = !legal;
  end
  assign bus.out_valid   = out_valid;
  assign bus.out_alu_op  = out_q.op;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_we      = out_q.we;
  assign bus.out_illegal = out_q.ill;
`ifdef SKID_BUFFER_EN
  logic  rdy, skid_valid, slot_free, in_fire;
  beat_t skid_q;
  assign slot_free    = !out_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && rdy;
  assign bus.in_ready = rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      rdy        <= 1'b1;
    end else if (slot_free) begin
      out_valid  <= skid_valid || in_fire;
      if (skid_valid) out_q <= skid_q;
      else if (in_fire) out_q <= dec;
      skid_valid <= 1'b0;
      rdy        <= 1'b1;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_q     <= dec;
      rdy        <= 1'b0;
    end
  end
`else
  assign bus.in_ready = !out_valid || bus.out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (bus.in_ready) begin
      out_valid <= bus.in_valid;
      if (bus.in_valid) out_q <= dec;
    end
  end
`endif
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed decode, flow-control and reset checks for alu_decode_stage
module tb_alu_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  alu_decode_stage_if #(.XLEN(64)) b1 ();
  alu_decode_stage_if #(.XLEN(64)) b0 ();
  alu_decode_stage #(.XLEN(64), .ZBA(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  alu_decode_stage #(.XLEN(64), .ZBA(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  assign b0.in_valid    = b1.in_valid;
  assign b0.in_instr    = b1.in_instr;
  assign b0.in_rs1_data = b1.in_rs1_data;
  assign b0.in_rs2_data = b1.in_rs2_data;
  assign b0.out_ready   = b1.out_ready;
  logic [138:0] o1;
  logic [5:0]   f0;
  assign o1 = {b1.out_alu_op, b1.out_a, b1.out_b, b1.out_rd, b1.out_we, b1.out_illegal};
  assign f0 = {b0.out_alu_op, b0.out_we, b0.out_illegal};
  task automatic send(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
    b1.out_ready   = 1'b1;
    b1.in_valid    = 1'b1;
    b1.in_instr    = ins;
    b1.in_rs1_data = r1;
    b1.in_rs2_data = r2;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
  endtask
  task automatic test_reset();
    b1.in_valid = 1'b0; b1.in_instr = '0; b1.in_rs1_data = '0; b1.in_rs2_data = '0; b1.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({b1.out_valid, o1} !== 140'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {b1.out_valid, o1}); end
    n_cmp++;
    if (b1.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", b1.in_ready); end
  endtask
  task automatic test_add();
    send(32'h002081B3, 64'd5, 64'd7);
    n_cmp++;
    if (b1.out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", b1.out_valid); end
    n_cmp++;
    if (o1 !== {4'h0, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0}) begin n_bad++; $display("FAIL add: got %h want %h", o1, {4'h0, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0}); end
  endtask
  task automatic test_addi_sub();
    send(32'hFFF00093, 64'd9, 64'd3);
    n_cmp++;
    if (o1 !== {4'h0, 64'd9, {64{1'b1}}, 5'd1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL addi: got %h want %h", o1, {4'h0, 64'd9, {64{1'b1}}, 5'd1, 1'b1, 1'b0}); end
    send(32'h407302B3, 64'd20, 64'd6);
    n_cmp++;
    if (o1 !== {4'h1, 64'd20, 64'd6, 5'd5, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sub: got %h want %h", o1, {4'h1, 64'd20, 64'd6, 5'd5, 1'b1, 1'b0}); end
  endtask
  task automatic test_zba();
    send(32'h2020E233, 64'd1, 64'd2);
    n_cmp++;
    if (o1 !== {4'h4, 64'd1, 64'd2, 5'd4, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sh3add: got %h want %h", o1, {4'h4, 64'd1, 64'd2, 5'd4, 1'b1, 1'b0}); end
    n_cmp++;
    if (f0 !== {4'h0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL sh3add_nozba: got %h want %h", f0, {4'h0, 1'b0, 1'b1}); end
    send(32'h2020A233, 64'd1, 64'd2);
    n_cmp++;
    if ({b1.out_alu_op, b1.out_we, b1.out_illegal} !== {4'h2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sh1add: got op=%h we=%b ill=%b want op=2 we=1 ill=0", b1.out_alu_op, b1.out_we, b1.out_illegal); end
    send(32'h2020C233, 64'd1, 64'd2);
    n_cmp++;
    if ({b1.out_alu_op, b1.out_we, b1.out_illegal} !== {4'h3, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sh2add: got op=%h we=%b ill=%b want op=3 we=1 ill=0", b1.out_alu_op, b1.out_we, b1.out_illegal); end
    n_cmp++;
    if (f0 !== {4'h0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL sh2add_nozba: got %h want %h", f0, {4'h0, 1'b0, 1'b1}); end
  endtask
  task automatic test_illegal();
    send(32'h00000000, 64'd4, 64'd4);
    n_cmp++;
    if ({b1.out_alu_op, b1.out_rd, b1.out_we, b1.out_illegal} !== {4'h0, 5'd0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL zero_instr: got op=%h rd=%0d we=%b ill=%b want 0/0/0/1", b1.out_alu_op, b1.out_rd, b1.out_we, b1.out_illegal); end
    send(32'h00208033, 64'd4, 64'd4);
    n_cmp++;
    if ({b1.out_alu_op, b1.out_rd, b1.out_we, b1.out_illegal} !== {4'h0, 5'd0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL add_x0: got op=%h rd=%0d we=%b ill=%b want 0/0/0/0", b1.out_alu_op, b1.out_rd, b1.out_we, b1.out_illegal); end
    send(32'h002091B3, 64'd4, 64'd4);
    n_cmp++;
    if ({b1.out_alu_op, b1.out_rd, b1.out_we, b1.out_illegal} !== {4'h0, 5'd3, 1'b0, 1'b1}) begin n_bad++; $display("FAIL sll_illegal: got op=%h rd=%0d we=%b ill=%b want 0/3/0/1", b1.out_alu_op, b1.out_rd, b1.out_we, b1.out_illegal); end
  endtask
  task automatic test_backpressure();
    int n_in = 0;
    int n_out = 0;
    int occ;
    logic stalled = 1'b0;
    logic exp_rdy;
    logic [138:0] held = '0;
    logic [138:0] exp;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 80 && n_out < 8; c++) begin
      @(posedge clk); #1;
      b1.out_ready   = c[0];
      b1.in_valid    = n_in < 8;
      b1.in_instr    = {12'(n_in), 5'd0, 3'b000, 5'(n_in + 1), 7'b0010011};
      b1.in_rs1_data = 64'd100 + 64'(n_in);
      b1.in_rs2_data = 64'hDEAD;
      @(negedge clk);
      occ = n_in - n_out;
`ifdef SKID_BUFFER_EN
      exp_rdy = occ < 2;
`else
      exp_rdy = occ == 0 || b1.out_ready;
`endif
      n_cmp++;
      if ({b1.out_valid, b1.in_ready} !== {occ > 0, exp_rdy}) begin n_bad++; $display("FAIL bp_flow c=%0d: got valid=%b ready=%b want valid=%b ready=%b", c, b1.out_valid, b1.in_ready, occ > 0, exp_rdy); end
      if (stalled) begin
        n_cmp++;
        if (o1 !== held) begin n_bad++; $display("FAIL bp_stable c=%0d: got %h want %h", c, o1, held); end
      end
      if (b1.out_valid && b1.out_ready) begin
        exp = {4'h0, 64'd100 + 64'(n_out), 64'(n_out), 5'(n_out + 1), 1'b1, 1'b0};
        n_cmp++;
        if (o1 !== exp) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", n_out, o1, exp); end
        n_out++;
      end
      stalled = b1.out_valid && !b1.out_ready;
      held    = o1;
      if (b1.in_valid && b1.in_ready) n_in++;
    end
    n_cmp++;
    if (n_out != 8 || n_in != 8) begin n_bad++; $display("FAIL bp_count: got in=%0d out=%0d want 8/8", n_in, n_out); end
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
  endtask
  task automatic test_back_to_back();
    b1.out_ready = 1'b1; b1.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b1.in_instr = {12'(k + 40), 5'd0, 3'b000, 5'd9, 7'b0010011};
      b1.in_rs1_data = 64'(k);
      @(posedge clk); #1;
      n_cmp++;
      if ({b1.out_valid, b1.out_a, b1.out_b} !== {1'b1, 64'(k), 64'(k + 40)}) begin n_bad++; $display("FAIL b2b%0d: got valid=%b a=%h b=%h want 1/%h/%h", k, b1.out_valid, b1.out_a, b1.out_b, 64'(k), 64'(k + 40)); end
    end
    b1.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    b1.out_ready = 1'b0; b1.in_valid = 1'b1;
    b1.in_instr = 32'h002081B3; b1.in_rs1_data = 64'd11; b1.in_rs2_data = 64'd12;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (b1.out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_stalled: got %b want 1", b1.out_valid); end
    b1.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({b1.out_valid, o1} !== 140'd0) begin n_bad++; $display("FAIL rmid_outputs: got %h want 0", {b1.out_valid, o1}); end
    n_cmp++;
    if (b1.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", b1.in_ready); end
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_leftover: got %b want 0", b1.out_valid); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_addi_sub();
    test_zba();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
